// File: rtl/ab_butterfly_seq.sv
// Butterfly sequencer for a shared-address RAM_A/RAM_B pair: A[i] <= A[i]+B[i], B[i] <= A[i]-B[i]
// over an address window, with host pass-through access to the RAM nets while idle.
module ab_butterfly_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_din_A,
    input  logic [DATA_W-1:0] host_din_B,
    output logic              host_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din_A,
    output logic [DATA_W-1:0] ram_din_B,
    input  logic [DATA_W-1:0] ram_dout_A,
    input  logic [DATA_W-1:0] ram_dout_B
);

    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic [WC_W-1:0]          wcnt_q, wcnt_d;
    logic                     ovf_q, ovf_d;
    logic                     cap;
    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [DATA_W:0]   sum_ext, dif_ext;

    // A signed result overflows DATA_W when its two top bits of the extended form disagree.
    function automatic logic sgn_ovf(input logic signed [DATA_W:0] r);
        return r[DATA_W] ^ r[DATA_W-1];
    endfunction

    always_comb begin
        sum_ext = {a_q[DATA_W-1], a_q} + {b_q[DATA_W-1], b_q};
        dif_ext = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        ptr_d   = base;
                        cnt_d   = len;
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD: begin
                wcnt_d  = WC_W'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    cap     = 1'b1;
                    state_d = S_WR;
                end else begin
                    wcnt_d = wcnt_q - WC_W'(1);
                end
            end
            S_WR: begin
                ovf_d   = ovf_q | sgn_ovf(sum_ext) | sgn_ovf(dif_ext);
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q - (ADDR_W + 1)'(1);
                state_d = (cnt_q != (ADDR_W + 1)'(1)) ? S_RD : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand capture is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            a_q <= ram_dout_A;
            b_q <= ram_dout_B;
        end
    end

    assign busy     = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR);
    assign done     = (state_q == S_DONE);
    assign ovf      = ovf_q;
    assign host_gnt = !busy;

    always_comb begin
        if (busy) begin
            ram_addr  = ptr_q;
            ram_we    = (state_q == S_WR);
            ram_din_A = sum_ext[DATA_W-1:0];
            ram_din_B = dif_ext[DATA_W-1:0];
        end else begin
            ram_addr  = host_addr;
            ram_we    = host_we;
            ram_din_A = host_din_A;
            ram_din_B = host_din_B;
        end
    end

endmodule

// File: tb/tb_ab_butterfly_seq.sv
// Scoreboard bench for ab_butterfly_seq with a behavioural RAM pair (read latency 1).
module tb_ab_butterfly_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  base;
    logic [4:0]  len;
    logic        busy, done, ovf, host_gnt;
    logic [3:0]  host_addr;
    logic        host_we;
    logic [15:0] host_din_A, host_din_B;
    logic [3:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din_A, ram_din_B;
    logic [15:0] ram_dout_A, ram_dout_B;

    logic [15:0] mem_A [16];
    logic [15:0] mem_B [16];

    int   cyc = 0;
    int   t0 = 0;
    int   wr_all = 0;
    int   busy_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic rd_req = 1'b0;
    logic rd_pipe = 1'b0;

    logic [31:0] rd_exp_q[$];
    string       rd_nm_q[$];
    int          dn_lat_q[$];
    logic        dn_ovf_q[$];
    logic [3:0]  st_exp_q[$];
    logic [3:0]  st_msk_q[$];
    string       st_nm_q[$];
    int          cc_sel_q[$];
    int          cc_exp_q[$];
    string       cc_nm_q[$];

    ab_butterfly_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       (base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .host_addr  (host_addr),
        .host_we    (host_we),
        .host_din_A (host_din_A),
        .host_din_B (host_din_B),
        .host_gnt   (host_gnt),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din_A  (ram_din_A),
        .ram_din_B  (ram_din_B),
        .ram_dout_A (ram_dout_A),
        .ram_dout_B (ram_dout_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM pair: write on posedge, registered read (old data on same-address write).
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pipe <= rd_req;
        if (ram_we) begin
            mem_A[ram_addr] <= ram_din_A;
            mem_B[ram_addr] <= ram_din_B;
            wr_all          <= wr_all + 1;
        end
        ram_dout_A <= mem_A[ram_addr];
        ram_dout_B <= mem_B[ram_addr];
    end

    // Monitor: pops expectations whenever the DUT or the read path presents something.
    always @(negedge clk) begin
        logic [3:0]  act_st, e4, m4;
        logic [31:0] e32;
        string       nm;
        int          sel, ev, act, lat;
        logic        eo;
        act_st = {busy, done, ovf, host_gnt};
        while (st_exp_q.size() > 0) begin
            e4 = st_exp_q.pop_front(); m4 = st_msk_q.pop_front(); nm = st_nm_q.pop_front();
            n_vec++;
            if ((act_st & m4) != (e4 & m4)) begin
                n_err++;
                $display("FAIL %s: {busy,done,ovf,gnt} got %b want %b (mask %b)", nm, act_st, e4, m4);
            end
        end
        while (cc_exp_q.size() > 0) begin
            sel = cc_sel_q.pop_front(); ev = cc_exp_q.pop_front(); nm = cc_nm_q.pop_front();
            act = (sel == 0) ? wr_all : busy_cnt;
            n_vec++;
            if (act != ev) begin
                n_err++;
                $display("FAIL %s: count got %0d want %0d", nm, act, ev);
            end
        end
        if (rd_pipe) begin
            n_vec++;
            if (rd_exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %h want nothing", {ram_dout_A, ram_dout_B});
            end else begin
                e32 = rd_exp_q.pop_front(); nm = rd_nm_q.pop_front();
                if ({ram_dout_A, ram_dout_B} != e32) begin
                    n_err++;
                    $display("FAIL %s: A,B got %h,%h want %h,%h", nm, ram_dout_A, ram_dout_B,
                             e32[31:16], e32[15:0]);
                end
            end
        end
        if (done) begin
            n_vec++;
            lat = cyc - t0;
            if (dn_lat_q.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected: got pulse at latency %0d want none", lat);
            end else begin
                ev = dn_lat_q.pop_front(); eo = dn_ovf_q.pop_front();
                if (lat != ev || ovf != eo) begin
                    n_err++;
                    $display("FAIL done: latency/ovf got %0d/%b want %0d/%b", lat, ovf, ev, eo);
                end
            end
        end
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st_push(input string nm, input logic [3:0] msk, input logic [3:0] ex);
        st_nm_q.push_back(nm); st_msk_q.push_back(msk); st_exp_q.push_back(ex);
    endtask

    task automatic cc_push(input string nm, input int sel, input int ex);
        cc_nm_q.push_back(nm); cc_sel_q.push_back(sel); cc_exp_q.push_back(ex);
    endtask

    task automatic hwrite(input logic [3:0] a, input logic [15:0] da, input logic [15:0] db);
        host_addr = a; host_we = 1'b1; host_din_A = da; host_din_B = db;
        st_push($sformatf("gnt_wr@%0d", a), 4'b0001, 4'b0001);
        tick();
        host_we = 1'b0;
    endtask

    task automatic hread(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
        host_addr = a; host_we = 1'b0;
        rd_exp_q.push_back({ea, eb}); rd_nm_q.push_back($sformatf("rd@%0d", a));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic run(input logic [3:0] b, input logic [4:0] l);
        base = b; len = l; start = 1'b1; t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat, input logic ov);
        int n;
        n = 0;
        dn_lat_q.push_back(lat); dn_ovf_q.push_back(ov);
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) st_push("done_timeout", 4'b0100, 4'b0100);
        else st_push("done_not_busy", 4'b1000, 4'b0000);
    endtask

    initial begin
        int wsnap, bsnap;
        rst = 1'b0; start = 1'b0; base = '0; len = '0;
        host_addr = '0; host_we = 1'b0; host_din_A = '0; host_din_B = '0;
        tick(); tick();
        st_push("reset_state", 4'b1111, 4'b0001);
        tick();
        rst = 1'b1;
        tick();

        // Preload via pass-through.
        hwrite(4'd0, 16'h1234, 16'h4321);
        hwrite(4'd9, 16'h5678, 16'h8765);
        for (int i = 1; i <= 8; i++) hwrite(4'(i), 16'(i), 16'(2 * i));
        hread(4'd3, 16'h0003, 16'h0006);

        // base=1 len=8: A=3i, B=-i.
        run(4'd1, 5'd8);
        wait_done(25, 1'b0);
        tick();
        st_push("done_single", 4'b0100, 4'b0000);
        hread(4'd0, 16'h1234, 16'h4321);
        for (int i = 1; i <= 8; i++) hread(4'(i), 16'(3 * i), 16'(-i));
        hread(4'd9, 16'h5678, 16'h8765);

        // Overflow on add, then on subtract, then a clean pass clears it.
        hwrite(4'd0, 16'h7FFF, 16'h0001);
        run(4'd0, 5'd1);
        wait_done(4, 1'b1);
        tick();
        st_push("ovf_sticky", 4'b0010, 4'b0010);
        hread(4'd0, 16'h8000, 16'h7FFE);
        run(4'd0, 5'd1);
        wait_done(4, 1'b1);
        tick();
        hread(4'd0, 16'hFFFE, 16'h0002);
        run(4'd2, 5'd1);
        wait_done(4, 1'b0);
        tick();
        hread(4'd2, 16'h0004, 16'h0008);

        // Window wrap: 14,15,0,1 only.
        hwrite(4'd13, 16'h0100, 16'h0001);
        hwrite(4'd14, 16'h0100, 16'h0001);
        hwrite(4'd15, 16'h0100, 16'h0001);
        hwrite(4'd0, 16'h0100, 16'h0001);
        hwrite(4'd1, 16'h0100, 16'h0001);
        hwrite(4'd2, 16'h0100, 16'h0001);
        run(4'd14, 5'd4);
        wait_done(13, 1'b0);
        tick();
        hread(4'd13, 16'h0100, 16'h0001);
        hread(4'd14, 16'h0101, 16'h00FF);
        hread(4'd15, 16'h0101, 16'h00FF);
        hread(4'd0, 16'h0101, 16'h00FF);
        hread(4'd1, 16'h0101, 16'h00FF);
        hread(4'd2, 16'h0100, 16'h0001);

        // len=0: done next cycle, no write, never busy.
        wsnap = wr_all; bsnap = busy_cnt;
        run(4'd3, 5'd0);
        wait_done(1, 1'b0);
        tick();
        cc_push("len0_writes", 0, wsnap);
        cc_push("len0_busy", 1, bsnap);

        // len=16 covers every address exactly once.
        for (int i = 0; i < 16; i++) hwrite(4'(i), 16'(i), 16'h0001);
        wsnap = wr_all;
        run(4'd5, 5'd16);
        wait_done(49, 1'b0);
        tick();
        cc_push("len16_writes", 0, wsnap + 16);
        hread(4'd0, 16'h0001, 16'hFFFF);
        hread(4'd5, 16'h0006, 16'h0004);
        hread(4'd15, 16'h0010, 16'h000E);

        // Host write and a second start during a pass are both ignored.
        hwrite(4'd5, 16'h5555, 16'hAAAA);
        wsnap = wr_all;
        run(4'd10, 5'd2);
        tick();
        host_addr = 4'd5; host_we = 1'b1; host_din_A = 16'hDEAD; host_din_B = 16'hBEEF;
        st_push("gnt_low_in_pass", 4'b1001, 4'b1000);
        tick();
        base = 4'd0; len = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        host_we = 1'b0;
        wait_done(7, 1'b0);
        repeat (12) tick();
        cc_push("arb_writes", 0, wsnap + 2);
        hread(4'd5, 16'h5555, 16'hAAAA);
        hread(4'd10, 16'h0014, 16'h0002);
        hread(4'd11, 16'h0016, 16'h0002);
        hread(4'd0, 16'h0001, 16'hFFFF);

        // Reset after two elements abandons the pass.
        hwrite(4'd3, 16'h7FFF, 16'h0001);
        hwrite(4'd4, 16'h0001, 16'h0001);
        hwrite(4'd5, 16'h0001, 16'h0001);
        hwrite(4'd6, 16'h0001, 16'h0001);
        wsnap = wr_all;
        run(4'd3, 5'd4);
        repeat (6) tick();
        st_push("mid_pass_ovf", 4'b1010, 4'b1010);
        rst = 1'b0;
        tick();
        st_push("after_reset", 4'b1111, 4'b0001);
        rst = 1'b1;
        tick();
        cc_push("reset_writes", 0, wsnap + 2);
        hread(4'd3, 16'h8000, 16'h7FFE);
        hread(4'd4, 16'h0002, 16'h0000);
        hread(4'd5, 16'h0001, 16'h0001);
        hread(4'd6, 16'h0001, 16'h0001);
        hread(4'd7, 16'h0008, 16'h0006);
        run(4'd5, 5'd2);
        wait_done(7, 1'b0);
        tick();
        hread(4'd5, 16'h0002, 16'h0000);
        hread(4'd6, 16'h0002, 16'h0000);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
